// File: rtl/vga_ram_arbiter_if.sv
// Bundles the reader, writer and RAM-side signals of the spectrum/frame-buffer arbiter.
// Reader: rd_req/rd_addr -> rd_ack, then rd_valid/rd_data one cycle later.
// Writer: wr_req/wr_addr/wr_data/wr_be -> wr_ack. RAM: address/byteenable/chipselect/write/writedata/readdata.
//
// Modports:
//   slave  - the arbiter's view: it consumes requests and drives acks and the RAM pins.
//   master - the surroundings' view: requesters plus the RAM model or RAM wrapper.
interface vga_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  // Reader (VGA pixel fetch)
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  // Writer (FFT result store)
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              wr_ack;

  // Avalon-style single-port RAM pins
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata;

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_data, rd_valid,
    input  wr_req, wr_addr, wr_data, wr_be,
    output wr_ack,
    output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
    input  ram_readdata
  );

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_data, rd_valid,
    output wr_req, wr_addr, wr_data, wr_be,
    input  wr_ack,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
    output ram_readdata
  );
endinterface

// File: rtl/vga_ram_arbiter.sv
// Purpose: share one single-port 1024x32 RAM between the VGA reader (priority) and the FFT writer.
// Latency: acks are combinational in the request cycle; read data/rd_valid return one cycle after rd_ack.
// Backpressure: a denied requester holds req/addr/data until its ack; a starvation counter bounds the writer's wait.
//
// Ports:
//   clk          - system clock.
//   reset        - asynchronous, active-high; forces all grants low while asserted.
//   bus          - reader, writer and RAM pins (vga_ram_arbiter_if.slave).
//   starve_grant - pulses when the writer wins over a pending reader because of the starvation limit.
module vga_ram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  vga_ram_arbiter_if.slave  bus,
  output logic              starve_grant
);

  // The counter is 8 bits wide, so the limit is compared in 8 bits too.
  localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic       starve_hit;
  logic       grant_wr;
  logic       grant_rd;
  logic       rd_valid_q;

  assign starve_hit = (starve_cnt == LIMIT8);

  // Grant decision. The reader wins by default because display timing is
  // real-time; the writer wins when the reader is idle, or when it has already
  // been passed over STARVE_LIMIT times in a row. Reset masks both grants so
  // nothing reaches the RAM while the system is coming up.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (!reset) begin
      grant_wr = bus.wr_req & (~bus.rd_req | starve_hit);
      grant_rd = bus.rd_req & ~grant_wr;
    end
  end

  assign bus.wr_ack = grant_wr;
  assign bus.rd_ack = grant_rd;
  assign starve_grant = grant_wr & bus.rd_req;

  // RAM drive. Only one of read/write is granted per cycle, so a read and a
  // write never collide at the RAM. With no grant the address idles on the
  // reader's address; chipselect low makes its value irrelevant.
  assign bus.ram_chipselect = grant_rd | grant_wr;
  assign bus.ram_write      = grant_wr;
  assign bus.ram_address    = grant_wr ? bus.wr_addr : bus.rd_addr;
  assign bus.ram_writedata  = bus.wr_data;
  assign bus.ram_byteenable = grant_wr ? bus.wr_be : {BE_W{1'b1}};

  // The RAM registers its address, so its readdata output is already aligned
  // with rd_valid; it is passed straight through.
  assign bus.rd_data  = bus.ram_readdata;
  assign bus.rd_valid = rd_valid_q;

  // starve_cnt counts consecutive reader wins while the writer waits. It
  // restarts whenever the writer is served or stops asking. Because a reader
  // win with the writer waiting implies the limit was not yet reached, the
  // saturation guard is a safety net rather than a reachable case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= grant_rd;
      if (grant_wr || !bus.wr_req) begin
        starve_cnt <= 8'd0;
      end else if (grant_rd && !starve_hit) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Directed bench for vga_ram_arbiter with a registered-address 1024x32 RAM model.
// Inputs are driven 1 time unit after the rising edge and checked 1 unit later.
module tb_vga_ram_arbiter;

  logic clk;
  logic reset;
  logic starve_grant;
  int   errors;
  int   checks;

  vga_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) bus ();

  vga_ram_arbiter #(
    .ADDR_W(10), .DATA_W(32), .BE_W(4), .STARVE_LIMIT(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .starve_grant (starve_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address registered on chipselect, byte-enabled writes,
  // readdata is the unregistered word at the registered address.
  logic [31:0] mem     [0:1023];
  logic [31:0] exp_mem [0:1023];
  logic [9:0]  ram_addr_q;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin
    ram_addr_q = 10'd0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = pat(i);
      exp_mem[i] = pat(i);
    end
  end

  always @(posedge clk) begin
    if (bus.ram_chipselect) begin
      if (bus.ram_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_byteenable[b]) mem[bus.ram_address][b*8 +: 8] <= bus.ram_writedata[b*8 +: 8];
      end
      ram_addr_q <= bus.ram_address;
    end
  end

  assign bus.ram_readdata = mem[ram_addr_q];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_req  = 1'b0;
    bus.wr_req  = 1'b0;
    bus.wr_be   = 4'hF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr = 10'd3;
    bus.wr_req = 1'b1; bus.wr_addr = 10'd4; bus.wr_data = 32'h0; bus.wr_be = 4'hF;
    #2;
    checks++; if (bus.rd_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack got=%b want=0", bus.rd_ack); end
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack got=%b want=0", bus.wr_ack); end
    checks++; if (bus.ram_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b want=0", bus.ram_chipselect); end
    checks++; if (bus.ram_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b want=0", bus.ram_write); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid); end
    checks++; if (starve_grant !== 1'b0) begin errors++; $display("FAIL reset_starve got=%b want=0", starve_grant); end
    step(); step();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_rd_valid got=%b want=0", bus.rd_valid); end
    // Release with only the reader asking: granted in the first cycle.
    reset = 1'b0;
    bus.wr_req = 1'b0;
    #1;
    checks++; if (bus.rd_ack !== 1'b1) begin errors++; $display("FAIL release_rd_ack got=%b want=1", bus.rd_ack); end
    step();
    idle();
    #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL release_rd_valid got=%b want=1", bus.rd_valid); end
    checks++; if (bus.rd_data !== exp_mem[3]) begin errors++; $display("FAIL release_rd_data got=%h want=%h", bus.rd_data, exp_mem[3]); end
    step();
  endtask

  // Addresses 1..1023 then 0: no bubbles, and the wrap returns word 0.
  task automatic test_full_throughput();
    for (int k = 0; k <= 1024; k++) begin
      bus.rd_req  = (k < 1024);
      bus.rd_addr = 10'((k + 1) % 1024);
      #1;
      if (k < 1024) begin
        checks++; if (bus.rd_ack !== 1'b1) begin errors++; $display("FAIL stream_rd_ack k=%0d got=%b want=1", k, bus.rd_ack); end
      end
      if (k > 0) begin
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL stream_rd_valid k=%0d got=%b want=1", k, bus.rd_valid); end
        checks++; if (bus.rd_data !== exp_mem[k % 1024]) begin errors++; $display("FAIL stream_rd_data k=%0d got=%h want=%h", k, bus.rd_data, exp_mem[k % 1024]); end
      end
      step();
    end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL stream_tail_valid got=%b want=0", bus.rd_valid); end
  endtask

  task automatic test_single_write_read();
    bus.wr_req = 1'b1; bus.wr_addr = 10'h3A5; bus.wr_data = 32'hDEADBEEF; bus.wr_be = 4'hF;
    #1;
    checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL wr1_ack got=%b want=1", bus.wr_ack); end
    checks++; if (bus.ram_write !== 1'b1) begin errors++; $display("FAIL wr1_ram_write got=%b want=1", bus.ram_write); end
    checks++; if (bus.ram_address !== 10'h3A5) begin errors++; $display("FAIL wr1_ram_addr got=%h want=3a5", bus.ram_address); end
    checks++; if (starve_grant !== 1'b0) begin errors++; $display("FAIL wr1_starve got=%b want=0", starve_grant); end
    exp_mem[10'h3A5] = 32'hDEADBEEF;
    step();
    idle();
    step(); step();
    bus.rd_req = 1'b1; bus.rd_addr = 10'h3A5;
    #1;
    checks++; if (bus.rd_ack !== 1'b1) begin errors++; $display("FAIL rd1_ack got=%b want=1", bus.rd_ack); end
    checks++; if (bus.ram_write !== 1'b0) begin errors++; $display("FAIL rd1_ram_write got=%b want=0", bus.ram_write); end
    checks++; if (bus.ram_byteenable !== 4'hF) begin errors++; $display("FAIL rd1_be got=%h want=f", bus.ram_byteenable); end
    step();
    idle();
    #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rd1_valid got=%b want=1", bus.rd_valid); end
    checks++; if (bus.rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd1_data got=%h want=deadbeef", bus.rd_data); end
    step();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd1_valid_drop got=%b want=0", bus.rd_valid); end
  endtask

  // Back-to-back writes then an immediate read of the same word.
  task automatic test_byte_enables();
    bus.wr_req = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 32'h11223344; bus.wr_be = 4'hF;
    step();
    bus.wr_data = 32'hAABBCCDD; bus.wr_be = 4'b0101;
    #1;
    checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL be_wr_ack got=%b want=1", bus.wr_ack); end
    checks++; if (bus.ram_byteenable !== 4'b0101) begin errors++; $display("FAIL be_ram_be got=%h want=5", bus.ram_byteenable); end
    exp_mem[5] = 32'h11BB33DD;
    step();
    idle();
    bus.rd_req = 1'b1; bus.rd_addr = 10'd5;
    step();
    idle();
    #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL be_rd_valid got=%b want=1", bus.rd_valid); end
    checks++; if (bus.rd_data !== 32'h11BB33DD) begin errors++; $display("FAIL be_rd_data got=%h want=11bb33dd", bus.rd_data); end
    step();
  endtask

  // Reader streams 0..19 with the writer waiting from cycle 0:
  // 8 reads, the writer in cycle 8 (9th), reads resume in cycle 9.
  task automatic test_starvation();
    int  ri;
    int  prev_addr;
    bit  prev_rd;
    bit  wr_pending;
    bit  exp_rd;
    bit  exp_wr;
    ri = 0; prev_addr = 0; prev_rd = 1'b0; wr_pending = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      exp_wr = (c == 8);
      exp_rd = !exp_wr;
      bus.rd_req  = (ri < 20);
      bus.rd_addr = 10'(ri);
      bus.wr_req  = wr_pending;
      bus.wr_addr = 10'd200; bus.wr_data = 32'h5A5A0F0F; bus.wr_be = 4'hF;
      #1;
      checks++; if (bus.rd_ack !== exp_rd) begin errors++; $display("FAIL starve_rd_ack c=%0d got=%b want=%b", c, bus.rd_ack, exp_rd); end
      checks++; if (bus.wr_ack !== exp_wr) begin errors++; $display("FAIL starve_wr_ack c=%0d got=%b want=%b", c, bus.wr_ack, exp_wr); end
      checks++; if (starve_grant !== exp_wr) begin errors++; $display("FAIL starve_grant c=%0d got=%b want=%b", c, starve_grant, exp_wr); end
      if (c > 0) begin
        checks++; if (bus.rd_valid !== prev_rd) begin errors++; $display("FAIL starve_rd_valid c=%0d got=%b want=%b", c, bus.rd_valid, prev_rd); end
        if (prev_rd) begin
          checks++; if (bus.rd_data !== exp_mem[prev_addr]) begin errors++; $display("FAIL starve_rd_data c=%0d got=%h want=%h", c, bus.rd_data, exp_mem[prev_addr]); end
        end
      end
      if (exp_rd) begin prev_addr = ri; ri++; end
      if (exp_wr) begin wr_pending = 1'b0; exp_mem[200] = 32'h5A5A0F0F; end
      prev_rd = exp_rd;
      step();
    end
    idle();
    #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL starve_last_valid got=%b want=1", bus.rd_valid); end
    checks++; if (bus.rd_data !== exp_mem[19]) begin errors++; $display("FAIL starve_last_data got=%h want=%h", bus.rd_data, exp_mem[19]); end
    step();
  endtask

  task automatic test_writer_burst();
    for (int i = 0; i < 16; i++) begin
      bus.wr_req = 1'b1; bus.wr_addr = 10'(100 + i); bus.wr_data = 32'h7700_0000 + 32'(i * 257); bus.wr_be = 4'hF;
      #1;
      checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL burst_wr_ack i=%0d got=%b want=1", i, bus.wr_ack); end
      checks++; if (bus.ram_address !== 10'(100 + i)) begin errors++; $display("FAIL burst_addr i=%0d got=%0d want=%0d", i, bus.ram_address, 100 + i); end
      checks++; if (dut.starve_cnt !== 8'd0) begin errors++; $display("FAIL burst_starve_cnt i=%0d got=%0d want=0", i, dut.starve_cnt); end
      exp_mem[100 + i] = 32'h7700_0000 + 32'(i * 257);
      step();
    end
    idle();
    for (int k = 0; k <= 16; k++) begin
      bus.rd_req  = (k < 16);
      bus.rd_addr = 10'(100 + k);
      #1;
      if (k > 0) begin
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL burst_rb_valid k=%0d got=%b want=1", k, bus.rd_valid); end
        checks++; if (bus.rd_data !== exp_mem[99 + k]) begin errors++; $display("FAIL burst_rb_data k=%0d got=%h want=%h", k, bus.rd_data, exp_mem[99 + k]); end
      end
      step();
    end
  endtask

  // Write then two back-to-back reads: the word just written and the word
  // stored by the starved writer.
  task automatic test_back_to_back();
    bus.wr_req = 1'b1; bus.wr_addr = 10'd7; bus.wr_data = 32'h0BADF00D; bus.wr_be = 4'hF;
    step();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 10'd7;
    step();
    bus.rd_addr = 10'd200;
    #1;
    checks++; if (bus.rd_data !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_raw_data got=%h want=0badf00d", bus.rd_data); end
    step();
    idle();
    #1;
    checks++; if (bus.rd_data !== 32'h5A5A0F0F) begin errors++; $display("FAIL b2b_starved_word got=%h want=5a5a0f0f", bus.rd_data); end
    step();
  endtask

  task automatic test_reset_midstream();
    bus.rd_req = 1'b1; bus.rd_addr = 10'd9;
    step();
    bus.wr_req = 1'b1; bus.wr_addr = 10'd10;
    #1;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b want=1", bus.rd_valid); end
    reset = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got=%b want=0", bus.rd_valid); end
    checks++; if (bus.rd_ack !== 1'b0 || bus.wr_ack !== 1'b0) begin errors++; $display("FAIL mid_acks got=%b%b want=00", bus.rd_ack, bus.wr_ack); end
    checks++; if (bus.ram_chipselect !== 1'b0) begin errors++; $display("FAIL mid_cs got=%b want=0", bus.ram_chipselect); end
    step();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_next_valid got=%b want=0", bus.rd_valid); end
    reset = 1'b0;
    bus.wr_req = 1'b0;
    #1;
    checks++; if (bus.rd_ack !== 1'b1) begin errors++; $display("FAIL mid_resume_ack got=%b want=1", bus.rd_ack); end
    step();
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.rd_addr = 10'd0; bus.wr_addr = 10'd0; bus.wr_data = 32'd0;
    test_reset();
    test_full_throughput();
    test_single_write_read();
    test_byte_enables();
    test_starvation();
    test_writer_burst();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
